// File: rtl/mdio_pkg.sv
// MDIO Clause-22 responder: shared types and constants.
// Frame FSM states, opcodes, PHY ID words and register reset values.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    OPCODE,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA
  } mdio_state_t;

  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_READ  = 2'b10;
  localparam logic [5:0]  PRE_LEN  = 6'd32;

  localparam logic [15:0] PHY_ID1  = 16'h0141;
  localparam logic [15:0] PHY_ID2  = 16'h0CC2;
  localparam logic [15:0] REG0_RST = 16'h1140;
  localparam logic [15:0] REG1_RST = 16'h7949;

  function automatic logic [15:0] reg_rst(input logic [4:0] a);
    case (a)
      5'd0:    return REG0_RST;
      5'd1:    return REG1_RST;
      5'd2:    return PHY_ID1;
      5'd3:    return PHY_ID2;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic is_ro(input logic [4:0] a);
    return (a == 5'd2) || (a == 5'd3);
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// MDC/MDIO input synchronizer with MDC rising-edge detect.
// mdio_s is aligned with the cycle mdc_rise is high.
module mdio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_q;
  logic [SYNC_STAGES-1:0] mdio_q;
  logic                   mdc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_q  <= '0;
      mdio_q <= '0;
      mdc_d  <= 1'b0;
    end else begin
      mdc_q  <= (mdc_q << 1) | SYNC_STAGES'(mdc_i);
      mdio_q <= (mdio_q << 1) | SYNC_STAGES'(mdio_i);
      mdc_d  <= mdc_q[SYNC_STAGES-1];
    end
  end

  assign mdc_rise = mdc_q[SYNC_STAGES-1] & ~mdc_d;
  assign mdio_s   = mdio_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO management responder with a 32 x 16 register file.
// One bit is consumed per synchronized MDC rising edge.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        wr_strobe,
  output logic [4:0]  wr_regad,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  logic        mdc_rise;
  logic        mdio_s;

  mdio_state_t state;
  logic [4:0]  bit_cnt;
  logic [5:0]  ones;
  logic        is_rd;
  logic [15:0] sh;
  logic [15:0] sh_nx;
  logic [4:0]  regad;
  logic [15:0] rd_sh;
  logic [15:0] regs [32];

  mdio_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .mdc_i   (mdc_i),
    .mdio_i  (mdio_i),
    .mdc_rise(mdc_rise),
    .mdio_s  (mdio_s)
  );

  assign sh_nx = {sh[14:0], mdio_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ones      <= '0;
      is_rd     <= 1'b0;
      sh        <= '0;
      regad     <= '0;
      rd_sh     <= '0;
      mdio_o    <= 1'b0;
      mdio_t    <= 1'b1;
      wr_strobe <= 1'b0;
      wr_regad  <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= reg_rst(5'(i));
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (mdc_rise) begin
        sh      <= sh_nx;
        bit_cnt <= bit_cnt + 5'd1;
        unique case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (mdio_s) begin
              if (ones != PRE_LEN) ones <= ones + 6'd1;
            end else begin
              ones <= '0;
              if (ones == PRE_LEN) state <= START;
            end
          end
          START: begin
            bit_cnt <= '0;
            if (mdio_s) begin
              state <= OPCODE;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
          OPCODE: if (bit_cnt == 5'd1) begin
            bit_cnt <= '0;
            if (sh_nx[1:0] == OP_WRITE) begin
              is_rd <= 1'b0;
              state <= PHYAD;
            end else if (sh_nx[1:0] == OP_READ) begin
              is_rd <= 1'b1;
              state <= PHYAD;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
          PHYAD: if (bit_cnt == 5'd4) begin
            bit_cnt <= '0;
            state   <= (sh_nx[4:0] == PHY_ADDR) ? REGAD : IDLE;
          end
          REGAD: if (bit_cnt == 5'd4) begin
            // snapshot read data so a later write cannot tear the frame
            bit_cnt <= '0;
            regad   <= sh_nx[4:0];
            rd_sh   <= regs[sh_nx[4:0]];
            state   <= TA;
          end
          TA: begin
            if (is_rd) begin
              if (bit_cnt == 5'd1) begin
                mdio_t  <= 1'b0;
                mdio_o  <= 1'b0;
                bit_cnt <= '0;
                state   <= RDATA;
              end
            end else if (mdio_s != (bit_cnt == 5'd0)) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          WDATA: if (bit_cnt == 5'd15) begin
            state <= IDLE;
            if (!is_ro(regad)) begin
              regs[regad] <= sh_nx;
              wr_strobe   <= 1'b1;
              wr_regad    <= regad;
              wr_data     <= sh_nx;
            end
          end
          RDATA: begin
            if (bit_cnt == 5'd16) begin
              mdio_t <= 1'b1;
              mdio_o <= 1'b0;
              state  <= IDLE;
            end else begin
              mdio_o <= rd_sh[15];
              rd_sh  <= {rd_sh[14:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: directed frame table, random frames
// against a field-level model, and a reset-during-read sequence.
module tb_mdio_responder;

  localparam int HALF = 4;

  typedef struct {
    int         pre;
    logic [31:0] word;
    bit         err;
    bit         wr;
    logic [4:0] regad;
    logic [15:0] data;
    bit         rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdc = 1'b0;
  logic        mdio = 1'b0;
  logic        mdio_o;
  logic        mdio_t;
  logic        wr_strobe;
  logic [4:0]  wr_regad;
  logic [15:0] wr_data;
  logic        frame_err;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  logic [4:0]  last_regad = '0;
  logic [15:0] last_data = '0;
  logic samp_t[$];
  logic samp_o[$];
  logic [15:0] mregs [32];
  vec_t tbl[$];

  always #5 clk = ~clk;

  mdio_responder #(
    .PHY_ADDR   (5'd1),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mdc_i    (mdc),
    .mdio_i   (mdio),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .wr_strobe(wr_strobe),
    .wr_regad (wr_regad),
    .wr_data  (wr_data),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (wr_strobe) begin
      wr_cnt     <= wr_cnt + 1;
      last_regad <= wr_regad;
      last_data  <= wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 16'h0000;
    mregs[0] = 16'h1140;
    mregs[1] = 16'h7949;
    mregs[2] = 16'h0141;
    mregs[3] = 16'h0CC2;
  endtask

  // word bit 0 goes on the wire first
  function automatic logic [31:0] mw(input logic [1:0] st, op,
                                     input logic [4:0] phy, ra,
                                     input logic [1:0] ta,
                                     input logic [15:0] d);
    logic [31:0] w;
    w[0] = st[1];
    w[1] = st[0];
    w[2] = op[1];
    w[3] = op[0];
    for (int i = 0; i < 5; i++) begin
      w[4+i] = phy[4-i];
      w[9+i] = ra[4-i];
    end
    w[14] = ta[1];
    w[15] = ta[0];
    for (int i = 0; i < 16; i++) w[16+i] = d[15-i];
    return w;
  endfunction

  function automatic vec_t predict(input int pre, input logic [31:0] w);
    vec_t v;
    logic [1:0] st, op, ta;
    logic [4:0] phy, ra;
    logic [15:0] d;
    v.pre = pre;
    v.word = w;
    v.err = 1'b0;
    v.wr = 1'b0;
    v.rd = 1'b0;
    v.regad = '0;
    v.data = '0;
    st = {w[0], w[1]};
    op = {w[2], w[3]};
    ta = {w[14], w[15]};
    for (int i = 0; i < 5; i++) begin
      phy[4-i] = w[4+i];
      ra[4-i] = w[9+i];
    end
    for (int i = 0; i < 16; i++) d[15-i] = w[16+i];
    if (pre < 32) return v;
    if (st != 2'b01 || !(op == 2'b01 || op == 2'b10)) begin
      v.err = 1'b1;
      return v;
    end
    if (phy != 5'd1) return v;
    if (op == 2'b10) begin
      v.rd = 1'b1;
      v.data = mregs[ra];
      return v;
    end
    if (ta != 2'b10) begin
      v.err = 1'b1;
      return v;
    end
    if (ra == 5'd2 || ra == 5'd3) return v;
    v.wr = 1'b1;
    v.regad = ra;
    v.data = d;
    return v;
  endfunction

  // station samples the bus just before raising MDC
  task automatic clock_bit(input logic b);
    mdc = 1'b0;
    mdio = b;
    repeat (HALF) @(negedge clk);
    samp_t.push_back(mdio_t);
    samp_o.push_back(mdio_o);
    mdc = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input string tag);
    int e0;
    int w0;
    int bad;
    int f;
    logic et, eo;
    e0 = err_cnt;
    w0 = wr_cnt;
    samp_t.delete();
    samp_o.delete();
    repeat (v.pre) clock_bit(1'b1);
    for (int i = 0; i < 32; i++) clock_bit(v.word[i]);
    repeat (3) clock_bit(1'b0);
    repeat (2) @(negedge clk);
    chk({tag, " frame_err_pulses"}, 32'(err_cnt - e0), 32'(v.err));
    chk({tag, " wr_strobe_pulses"}, 32'(wr_cnt - w0), 32'(v.wr));
    if (v.wr) begin
      chk({tag, " wr_regad"}, 32'(last_regad), 32'(v.regad));
      chk({tag, " wr_data"}, 32'(last_data), 32'(v.data));
      mregs[v.regad] = v.data;
    end
    bad = -1;
    for (int i = 0; i < samp_t.size(); i++) begin
      f = i - v.pre;
      et = 1'b1;
      eo = 1'b0;
      if (v.rd && f >= 16 && f <= 32) et = 1'b0;
      if (v.rd && f >= 17 && f <= 32) eo = v.data[32-f];
      if (bad < 0 && (samp_t[i] !== et || samp_o[i] !== eo)) bad = i;
    end
    chk({tag, " bus_first_bad_bit"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  initial begin
    vec_t v;
    int pre;
    int r;
    logic [1:0] st, op, ta;
    logic [4:0] phy, ra;
    logic [15:0] d, d0;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    chk("rst mdio_t", 32'(mdio_t), 32'd1);
    chk("rst mdio_o", 32'(mdio_o), 32'd0);
    chk("rst wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    chk("rst wr_regad", 32'(wr_regad), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    tbl.push_back(vec_t'{32, 32'h008C410A, 1'b0, 1'b1, 5'd0, 16'h3100, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd0, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h3100, 1'b1});
    tbl.push_back(vec_t'{32, 32'h0000650A, 1'b0, 1'b1, 5'd9, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, 32'h00CC410A, 1'b0, 1'b1, 5'd0, 16'h3300, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd0, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h3300, 1'b1});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h0141, 1'b1});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd3, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h0CC2, 1'b1});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd1, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h7949, 1'b1});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd9, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h0000, 1'b1});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b01, 5'd2, 5'd5, 2'b10, 16'hBEEF),
                         1'b0, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b01, 5'd1, 5'd5, 2'b10, 16'hA5A5),
                         1'b0, 1'b1, 5'd5, 16'hA5A5, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd2, 5'd0, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{31, mw(2'b01, 2'b01, 5'd1, 5'd6, 2'b10, 16'h1234),
                         1'b0, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd6, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h0000, 1'b1});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b11, 5'd1, 5'd0, 2'b10, 16'h0000),
                         1'b1, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd3, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h0CC2, 1'b1});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b00, 5'd1, 5'd0, 2'b10, 16'h0000),
                         1'b1, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b00, 2'b01, 5'd1, 5'd0, 2'b10, 16'h0000),
                         1'b1, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b01, 5'd1, 5'd7, 2'b11, 16'h7777),
                         1'b1, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b01, 5'd0, 5'd7, 2'b10, 16'h7777),
                         1'b0, 1'b0, 5'd0, 16'h0000, 1'b0});
    tbl.push_back(vec_t'{32, mw(2'b01, 2'b10, 5'd1, 5'd5, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'hA5A5, 1'b1});
    tbl.push_back(vec_t'{40, mw(2'b01, 2'b10, 5'd1, 5'd0, 2'b11, 16'hFFFF),
                         1'b0, 1'b0, 5'd0, 16'h3300, 1'b1});

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    for (int k = 0; k < 36; k++) begin
      pre = ($urandom_range(0, 7) == 0) ? 31 : 32 + $urandom_range(0, 3);
      st = (pre >= 32 && $urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      phy = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
      ra = 5'($urandom_range(0, 7));
      ta = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b10;
      d = 16'($urandom);
      v = predict(pre, mw(st, op, phy, ra, ta, d));
      apply(v, $sformatf("rnd%0d", k));
    end

    // reset while the 8th read data bit is on the bus
    d0 = mregs[0];
    w = mw(2'b01, 2'b10, 5'd1, 5'd0, 2'b11, 16'hFFFF);
    repeat (32) clock_bit(1'b1);
    for (int i = 0; i < 24; i++) clock_bit(w[i]);
    chk("midread mdio_t", 32'(mdio_t), 32'd0);
    chk("midread mdio_o", 32'(mdio_o), 32'(d0[8]));
    #2 reset = 1'b1;
    #1;
    chk("async rst mdio_t", 32'(mdio_t), 32'd1);
    chk("async rst mdio_o", 32'(mdio_o), 32'd0);
    mdc = 1'b0;
    mdio = 1'b0;
    repeat (3) @(negedge clk);
    chk("in rst wr_strobe", 32'(wr_strobe), 32'd0);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    apply(predict(32, mw(2'b01, 2'b10, 5'd1, 5'd0, 2'b11, 16'hFFFF)), "post_rst rd0");
    apply(predict(32, mw(2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'h5A5A)), "post_rst wr4");
    apply(predict(32, mw(2'b01, 2'b10, 5'd1, 5'd4, 2'b11, 16'hFFFF)), "post_rst rd4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
